card_dealer: RTL and testbench

Producer side of the card hand interface. On each deal request it draws a pseudo-random rank (1..13) and writes it into the next free slot of the player hand on `SM_if`. The hand value calculator and the game state machine then read those slots. The block owns slot fill order, the hand card count, round clearing and an optional per-round 52-card deck constraint.

---
 rtl/card_pkg.sv | 27 ++
 rtl/sm_if.sv | 14 +
 rtl/card_dealer_lfsr16.sv | 26 ++
 rtl/card_dealer.sv | 147 ++++++++++++++
 tb/tb_card_dealer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/card_pkg.sv
// Shared card encodings, hand size and dealer FSM state type for the card hand
// producer and its consumers.
package card_pkg;

  localparam int HAND_SLOTS  = 9;
  localparam int NUM_RANKS   = 13;
  localparam int DECK_COPIES = 4;

  typedef logic [3:0] card_t;

  localparam card_t RANK_EMPTY = 4'd0;
  localparam card_t RANK_ACE   = 4'd1;
  localparam card_t RANK_KING  = 4'd13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAW,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } dealer_state_e;

  function automatic logic rank_valid(input card_t c);
    return (c >= RANK_ACE) && (c <= RANK_KING);
  endfunction

endpackage

// File: rtl/sm_if.sv
// Player hand slots shared between the dealer (producer) and the hand value
// calculator / game state machine (consumers).
interface SM_if
  import card_pkg::*;
#(
  parameter int SLOTS = HAND_SLOTS
);

  card_t player_card_values [SLOTS];

  modport out (output player_card_values);
  modport in  (input  player_card_values);

endinterface

// File: rtl/card_dealer_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), shared by the player
// and dealer hand blocks.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/card_dealer.sv
// Player hand producer: deals pseudo-random ranks into the next free hand slot.
// Optional per-round 52-card deck limit enabled by CARD_DEALER_DECK_TRACK_EN.
module card_dealer
  import card_pkg::*;
#(
  parameter int          SLOTS     = HAND_SLOTS,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       deal_req,
  input  logic       new_round,
  output logic       deal_done,
  output logic       deal_err,
  output logic       busy,
  output logic [3:0] card_count,
  output logic [3:0] last_card,
  SM_if.out          card_if
);

  dealer_state_e state_q, state_d;
  card_t         cand_q, cand_d;
  card_t         last_q, last_d;
  logic [3:0]    count_q, count_d;
  card_t         slot_q [SLOTS];
  card_t         slot_d [SLOTS];
  logic          done_q, done_d;
  logic          err_q, err_d;

  card_t         draw;
  logic [11:0]   lfsr_unused;
  logic          draw_ok;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   ({lfsr_unused, draw})
  );

`ifdef CARD_DEALER_DECK_TRACK_EN
  logic [2:0] deck_q [NUM_RANKS];
  logic [2:0] deck_d [NUM_RANKS];

  always_comb begin
    draw_ok = rank_valid(draw);
    for (int r = 0; r < NUM_RANKS; r++) begin
      if (draw == card_t'(r + 1) && deck_q[r] == 3'(DECK_COPIES)) draw_ok = 1'b0;
    end
  end
`else
  always_comb begin
    draw_ok = rank_valid(draw);
  end
`endif

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    last_d  = last_q;
    count_d = count_q;
    slot_d  = slot_q;
`ifdef CARD_DEALER_DECK_TRACK_EN
    deck_d  = deck_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (deal_req) state_d = (count_q < 4'(SLOTS)) ? ST_DRAW : ST_ERR;
      end
      ST_DRAW: begin
        if (draw_ok) begin
          cand_d  = draw;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        for (int i = 0; i < SLOTS; i++) begin
          if (count_q == 4'(i)) slot_d[i] = cand_q;
        end
`ifdef CARD_DEALER_DECK_TRACK_EN
        for (int r = 0; r < NUM_RANKS; r++) begin
          if (cand_q == card_t'(r + 1)) deck_d[r] = deck_q[r] + 3'd1;
        end
`endif
        count_d = count_q + 4'd1;
        last_d  = cand_q;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A new round overrides everything, including a deal in flight.
    if (new_round) begin
      state_d = ST_IDLE;
      count_d = '0;
      last_d  = RANK_EMPTY;
      for (int i = 0; i < SLOTS; i++) slot_d[i] = RANK_EMPTY;
`ifdef CARD_DEALER_DECK_TRACK_EN
      for (int r = 0; r < NUM_RANKS; r++) deck_d[r] = '0;
`endif
    end

    done_d = (state_d == ST_DONE);
    err_d  = (state_d == ST_ERR);
  end

  // NOTE: the slot array is reset explicitly because 0 is the architectural "empty" marker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cand_q  <= RANK_EMPTY;
      last_q  <= RANK_EMPTY;
      count_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < SLOTS; i++) slot_q[i] <= RANK_EMPTY;
`ifdef CARD_DEALER_DECK_TRACK_EN
      for (int r = 0; r < NUM_RANKS; r++) deck_q[r] <= '0;
`endif
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      last_q  <= last_d;
      count_q <= count_d;
      done_q  <= done_d;
      err_q   <= err_d;
      slot_q  <= slot_d;
`ifdef CARD_DEALER_DECK_TRACK_EN
      deck_q  <= deck_d;
`endif
    end
  end

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot_out
    assign card_if.player_card_values[g] = slot_q[g];
  end

  assign busy       = (state_q != ST_IDLE);
  assign deal_done  = done_q;
  assign deal_err   = err_q;
  assign card_count = count_q;
  assign last_card  = last_q;

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: reset, single and held deals, full-hand refusal,
// abort/priority of new_round, and per-round deck limit when CARD_DEALER_DECK_TRACK_EN is set.
module tb_card_dealer;
  import card_pkg::*;

  localparam logic [15:0] TB_SEED = 16'h0001;
  localparam int          NSLOT   = 9;

  logic       clk = 1'b0;
  logic       rst;
  logic       deal_req;
  logic       new_round;
  logic       deal_done;
  logic       deal_err;
  logic       busy;
  logic [3:0] card_count;
  logic [3:0] last_card;

  SM_if #(.SLOTS(NSLOT)) hand_if ();

  card_dealer #(.SLOTS(NSLOT), .LFSR_SEED(TB_SEED)) dut (
    .clk        (clk),
    .rst        (rst),
    .deal_req   (deal_req),
    .new_round  (new_round),
    .deal_done  (deal_done),
    .deal_err   (deal_err),
    .busy       (busy),
    .card_count (card_count),
    .last_card  (last_card),
    .card_if    (hand_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference LFSR, Fibonacci taps 16,14,13,11, free running from reset.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  logic [15:0] m_lfsr;
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= TB_SEED;
    else     m_lfsr <= lfsr_next(m_lfsr);
  end

  card_t exp_hand [NSLOT];
  int    exp_count;
  int    rank_cnt [NUM_RANKS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void predict(input logic [15:0] start, output card_t c, output int rej);
    logic [15:0] s;
    card_t       nib;
    bit          ok;
    s   = start;
    rej = 0;
    c   = RANK_EMPTY;
    for (int k = 0; k < 200; k++) begin
      nib = s[3:0];
      ok  = (nib >= 4'd1) && (nib <= 4'd13);
`ifdef CARD_DEALER_DECK_TRACK_EN
      if (ok && rank_cnt[int'(nib) - 1] >= DECK_COPIES) ok = 1'b0;
`endif
      if (ok) begin
        c = nib;
        return;
      end
      s = lfsr_next(s);
      rej++;
    end
  endfunction

  function automatic int hand_mismatches();
    int m = 0;
    for (int i = 0; i < NSLOT; i++) begin
      if (hand_if.player_card_values[i] !== exp_hand[i]) m++;
    end
    return m;
  endfunction

  task automatic clear_model();
    exp_count = 0;
    for (int i = 0; i < NSLOT; i++) exp_hand[i] = RANK_EMPTY;
    for (int r = 0; r < NUM_RANKS; r++) rank_cnt[r] = 0;
  endtask

  // Starts and ends at a falling edge in an IDLE cycle. keep leaves deal_req high.
  task automatic deal(input bit keep);
    card_t c;
    int    rej;
    int    n;
    int    idx;
    idx      = exp_count;
    deal_req = 1'b1;
    @(negedge clk);
    if (!keep) deal_req = 1'b0;
    predict(m_lfsr, c, rej);
    check("busy_in_draw", busy, 1);
    n = 0;
    while (deal_done !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("done_latency", n, rej + 2);
    check("last_card", last_card, c);
    check("slot_value", hand_if.player_card_values[idx], c);
    check("card_count", card_count, idx + 1);
    exp_hand[idx] = c;
    exp_count     = idx + 1;
    rank_cnt[int'(c) - 1]++;
    @(negedge clk);
    check("done_one_cycle", {busy, deal_done}, 0);
  endtask

  task automatic do_new_round();
    new_round = 1'b1;
    deal_req  = 1'b0;
    @(negedge clk);
    new_round = 1'b0;
    clear_model();
    check("nr_count", card_count, 0);
    check("nr_last", last_card, 0);
    check("nr_slots", hand_mismatches(), 0);
    check("nr_busy", busy, 0);
  endtask

  initial begin
    int quiet;
    int maxr;
    int occ [NUM_RANKS];

    rst       = 1'b1;
    deal_req  = 1'b0;
    new_round = 1'b0;
    clear_model();

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_pulses", {deal_done, deal_err}, 0);
    check("rst_count", card_count, 0);
    check("rst_last", last_card, 0);
    check("rst_slots", hand_mismatches(), 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_quiet", {busy, deal_done, deal_err}, 0);
    end
    check("idle_slots", hand_mismatches(), 0);

    // Single request pulse.
    deal(1'b0);
    check("single_rest_empty", hand_mismatches(), 0);

    // Nine deals with deal_req held, then a refused tenth request.
    do_new_round();
    for (int d = 0; d < NSLOT; d++) deal(1'b1);
    @(negedge clk);
    deal_req = 1'b0;
    check("full_err_pulse", {busy, deal_err, deal_done}, 3'b110);
    @(negedge clk);
    check("err_one_cycle", {busy, deal_err}, 0);
    check("full_count", card_count, NSLOT);
    check("full_hand_kept", hand_mismatches(), 0);

    // new_round while in DRAW aborts the deal.
    do_new_round();
    deal(1'b0);
    deal_req = 1'b1;
    @(negedge clk);
    check("abort_in_draw", busy, 1);
    deal_req  = 1'b0;
    new_round = 1'b1;
    @(negedge clk);
    new_round = 1'b0;
    clear_model();
    check("abort_count", card_count, 0);
    check("abort_last", last_card, 0);
    check("abort_slots", hand_mismatches(), 0);
    quiet = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy !== 1'b0 || deal_done !== 1'b0) quiet++;
      @(negedge clk);
    end
    check("abort_no_done", quiet, 0);

    // new_round and deal_req together: clear wins, no deal starts.
    deal(1'b0);
    deal_req  = 1'b1;
    new_round = 1'b1;
    @(negedge clk);
    deal_req  = 1'b0;
    new_round = 1'b0;
    clear_model();
    check("prio_count", card_count, 0);
    check("prio_slots", hand_mismatches(), 0);
    quiet = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy !== 1'b0 || deal_done !== 1'b0 || deal_err !== 1'b0) quiet++;
      @(negedge clk);
    end
    check("prio_no_deal", quiet, 0);

    // Thirteen full rounds.
    for (int r = 0; r < 13; r++) begin
      do_new_round();
      for (int d = 0; d < NSLOT; d++) deal(1'b1);
      deal_req = 1'b0;
      check("round_hand", hand_mismatches(), 0);
`ifdef CARD_DEALER_DECK_TRACK_EN
      for (int k = 0; k < NUM_RANKS; k++) occ[k] = 0;
      for (int i = 0; i < NSLOT; i++) begin
        if (rank_valid(hand_if.player_card_values[i]))
          occ[int'(hand_if.player_card_values[i]) - 1]++;
      end
      maxr = 0;
      for (int k = 0; k < NUM_RANKS; k++) if (occ[k] > maxr) maxr = occ[k];
      check("deck_limit", (maxr <= DECK_COPIES), 1);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
